// File: rtl/soc_or1k_boot_pkg.sv
// Shared state encoding and Wishbone constants for the OR1K boot sequencer.
package soc_or1k_boot_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, HOLD, RUN, ERROR} boot_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam int         WORD_BYTES  = 4;
endpackage

// File: rtl/soc_or1k_reset_stagger.sv
// Per-core reset release: core k leaves reset when the hold counter reaches
// RST_HOLD + k*STAGGER, counting from 0 on the cycle after start.
module soc_or1k_reset_stagger #(
  parameter int NUM_CORES = 1,
  parameter int RST_HOLD  = 16,
  parameter int STAGGER   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 start,
  output logic [NUM_CORES-1:0] cpu_rst,
  output logic                 all_released
);
  logic [31:0]          cnt_reg;
  logic                 running_reg;
  logic [NUM_CORES-1:0] rst_reg;
  logic [NUM_CORES-1:0] release_hit;

  // Compare against the count the register will hold after this edge.
  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      localparam logic [31:0] THRESH = 32'(RST_HOLD + gi * STAGGER);
      assign release_hit[gi] = running_reg && ((cnt_reg + 32'd1) == THRESH);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      running_reg <= 1'b0;
      rst_reg     <= '1;
    end else if (arm || start) begin
      cnt_reg     <= '0;
      running_reg <= start;
      rst_reg     <= '1;
    end else if (running_reg) begin
      cnt_reg <= cnt_reg + 32'd1;
      rst_reg <= rst_reg & ~release_hit;
      if (~|rst_reg) running_reg <= 1'b0;
    end
  end

  assign cpu_rst      = rst_reg;
  assign all_released = ~|rst_reg;
endmodule

// File: rtl/soc_or1k_wb_boot_sequencer.sv
// Boot sequencer: optional RAM clear, image load over a Wishbone classic
// write master, then staggered per-core reset release.
module soc_or1k_wb_boot_sequencer
  import soc_or1k_boot_pkg::*;
#(
  parameter int             AW        = 32,
  parameter int             DW        = 32,
  parameter int             NUM_CORES = 1,
  parameter logic [31:0]    MEM_SIZE  = 32'h0200_0000,
  parameter logic [AW-1:0]  BASE_ADDR = '0,
  parameter int             RST_HOLD  = 16,
  parameter int             STAGGER   = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [AW-1:0]        img_words_i,
  input  logic                 s_valid_i,
  input  logic [DW-1:0]        s_data_i,
  output logic                 s_ready_o,
  output logic [AW-1:0]        wbm_adr_o,
  output logic [DW-1:0]        wbm_dat_o,
  output logic [DW/8-1:0]      wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic [NUM_CORES-1:0] cpu_rst_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [AW-1:0]        words_o
);
  localparam logic [AW-1:0] CLEAR_WORDS = AW'(MEM_SIZE / WORD_BYTES);

  boot_state_t   state_reg, state_next;
  logic          cyc_reg, cyc_next;
  logic [AW-1:0] adr_reg, adr_next;
  logic [DW-1:0] dat_reg, dat_next;
  logic [AW-1:0] words_reg, words_next;
  logic [AW-1:0] len_reg, len_next;
  logic [AW-1:0] words_inc, word_adr;
  logic          arm, hold_start, all_released;

  assign words_inc = words_reg + AW'(1);
  assign word_adr  = BASE_ADDR + words_reg * AW'(WORD_BYTES);

  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    adr_next   = adr_reg;
    dat_next   = dat_reg;
    words_next = words_reg;
    len_next   = len_reg;
    arm        = 1'b0;
    case (state_reg)
      CLEAR: begin
        if (cyc_reg) begin
          if (wbm_err_i) begin
            cyc_next   = 1'b0;
            state_next = ERROR;
          end else if (wbm_ack_i) begin
            cyc_next   = 1'b0;
            words_next = words_inc;
            // Empty image: start the hold count from this last ack.
            if (words_inc == CLEAR_WORDS && len_reg == '0) begin
              words_next = '0;
              state_next = HOLD;
            end
          end
        end else if (words_reg == CLEAR_WORDS) begin
          words_next = '0;
          state_next = LOAD;
        end else begin
          cyc_next = 1'b1;
          adr_next = word_adr;
          dat_next = '0;
        end
      end
      LOAD: begin
        if (cyc_reg) begin
          if (wbm_err_i) begin
            cyc_next   = 1'b0;
            state_next = ERROR;
          end else if (wbm_ack_i) begin
            cyc_next   = 1'b0;
            words_next = words_inc;
            if (words_inc == len_reg) state_next = HOLD;
          end
        end else if (s_valid_i) begin
          cyc_next = 1'b1;
          adr_next = word_adr;
          dat_next = s_data_i;
        end
      end
      HOLD: begin
        if (all_released) state_next = RUN;
      end
      default: begin
        if (start_i) begin
          arm        = 1'b1;
          words_next = '0;
          len_next   = img_words_i;
          if (img_words_i > CLEAR_WORDS) state_next = ERROR;
          else if (clear_i)              state_next = CLEAR;
          else if (img_words_i == '0)    state_next = HOLD;
          else                           state_next = LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg <= IDLE;
      cyc_reg   <= 1'b0;
      adr_reg   <= '0;
      dat_reg   <= '0;
      words_reg <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      adr_reg   <= adr_next;
      dat_reg   <= dat_next;
      words_reg <= words_next;
      len_reg   <= len_next;
    end
  end

  assign hold_start = (state_next == HOLD) && (state_reg != HOLD);

  soc_or1k_reset_stagger #(
    .NUM_CORES (NUM_CORES),
    .RST_HOLD  (RST_HOLD),
    .STAGGER   (STAGGER)
  ) u_stagger (
    .clk          (wb_clk_i),
    .rst_n        (wb_rst_ni),
    .arm          (arm),
    .start        (hold_start),
    .cpu_rst      (cpu_rst_o),
    .all_released (all_released)
  );

  assign s_ready_o = (state_reg == LOAD) && !cyc_reg;
  assign wbm_adr_o = adr_reg;
  assign wbm_dat_o = dat_reg;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = cyc_reg;
  assign wbm_cyc_o = cyc_reg;
  assign wbm_stb_o = cyc_reg;
  assign wbm_cti_o = CTI_CLASSIC;
  assign wbm_bte_o = BTE_LINEAR;
  assign busy_o    = (state_reg == CLEAR) || (state_reg == LOAD) || (state_reg == HOLD);
  assign done_o    = (state_reg == RUN);
  assign error_o   = (state_reg == ERROR);
  assign words_o   = words_reg;
endmodule
